responder_iterator: RTL and testbench

//  Downstream stage of the tag register in the CAPP datapath. Takes a snapshot of
//  the WORDS-bit tag (responder) vector on start. Emits the word index of every set
//  tag, lowest index first, one per valid/ready handshake. Reports responder count
//  and some/none, so the controller can visit each responder for readout/writeback.

---
 rtl/responder_iterator.sv | 106 ++++++++++
 tb/tb_responder_iterator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/responder_iterator.sv
// Responder iterator: snapshots the CAPP tag vector on start and walks every set
// tag, lowest index first, one index per valid/ready handshake.
module responder_iterator #(
   parameter int WORDS = 100,
   parameter int IDX_W = 7      // 2**IDX_W must be >= WORDS
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WORDS-1:0] tags,
   input  logic             start,
   input  logic             abort,
   output logic             idx_valid,
   input  logic             idx_ready,
   output logic [IDX_W-1:0] idx,
   output logic             idx_last,
   output logic             busy,
   output logic             done,
   output logic [IDX_W:0]   count,
   output logic             any_resp
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [WORDS-1:0] ONE     = WORDS'(1);
   localparam logic [IDX_W:0]   CNT_ONE = (IDX_W + 1)'(1);

   state_t           state;
   state_t           next_state;
   logic [WORDS-1:0] pending;
   logic [WORDS-1:0] pending_clr;
   logic [IDX_W-1:0] low_idx;
   logic             one_left;
   logic             accept_start;
   logic             fire;

   // Lowest set bit of pending; scanning downwards lets the lowest match win.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      low_idx = '0;
      for (int i = WORDS - 1; i >= 0; i--) begin
         if (pending[i]) low_idx = IDX_W'(i);
      end
   end

   // x & (x-1) drops the lowest set bit, which is exactly the index being emitted.
   assign pending_clr = pending & (pending - ONE);
   assign one_left    = (pending != '0) && (pending_clr == '0);

   assign accept_start = (state == ST_IDLE) && start && !abort;
   assign fire         = idx_valid && idx_ready;

   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: if (start)            next_state = (|tags) ? ST_EMIT : ST_DONE;
            ST_EMIT: if (fire && idx_last) next_state = ST_DONE;
            ST_DONE:                       next_state = ST_IDLE;
            default:                       next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         state <= next_state;
      end
   end

   // The snapshot register is reset too, so idx/idx_last never expose stale tags.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pending  <= '0;
         count    <= '0;
         any_resp <= 1'b0;
      end else if (abort) begin
         pending <= '0;
      end else if (accept_start) begin
         pending  <= tags;
         count    <= '0;
         any_resp <= |tags;
      end else if (fire) begin
         pending <= pending_clr;
         count   <= count + CNT_ONE;
      end
   end

   always_comb begin
      idx_valid = (state == ST_EMIT);
      idx       = idx_valid ? low_idx  : '0;
      idx_last  = idx_valid ? one_left : 1'b0;
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
   end

endmodule

// File: tb/tb_responder_iterator.sv
// Directed bench for responder_iterator: snapshot walk, empty set, backpressure,
// ignored restart, abort and asynchronous reset during emission.
module tb_responder_iterator;

   localparam int WORDS = 100;
   localparam int IDX_W = 7;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic [WORDS-1:0] tags;
   logic             start;
   logic             abort;
   logic             idx_valid;
   logic             idx_ready;
   logic [IDX_W-1:0] idx;
   logic             idx_last;
   logic             busy;
   logic             done;
   logic [IDX_W:0]   count;
   logic             any_resp;

   int n_checks = 0;
   int n_fails  = 0;

   responder_iterator #(.WORDS(WORDS), .IDX_W(IDX_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .tags(tags), .start(start), .abort(abort),
      .idx_valid(idx_valid), .idx_ready(idx_ready), .idx(idx), .idx_last(idx_last),
      .busy(busy), .done(done), .count(count), .any_resp(any_resp)
   );

   always #5 CLK = ~CLK;

   // Outputs are sampled and inputs changed 1 time unit after each rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Packs {idx_valid, idx, idx_last} for compact handshake comparisons.
   function automatic logic [IDX_W+1:0] emit_vec(logic v, int i, logic l);
      return {v, IDX_W'(i), l};
   endfunction

   task automatic test_reset();
      RST_N = 1'b0; tags = '0; start = 0; abort = 0; idx_ready = 0;
      #3;
      n_checks++;
      if ({idx_valid, idx, idx_last, busy, done, count, any_resp} !== '0) begin
         $display("FAIL reset_outputs: got valid=%0b idx=%0d last=%0b busy=%0b done=%0b count=%0d any=%0b, want all 0",
                  idx_valid, idx, idx_last, busy, done, count, any_resp);
         n_fails++;
      end
      tick();
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int exp_idx [3] = '{3, 17, 99};
      tags = '0; tags[3] = 1; tags[17] = 1; tags[99] = 1;
      idx_ready = 1; start = 1;
      tick();
      start = 0;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if ({idx_valid, idx, idx_last} !== emit_vec(1'b1, exp_idx[k], k == 2)) begin
            $display("FAIL basic_emit%0d: got valid=%0b idx=%0d last=%0b, want valid=1 idx=%0d last=%0b",
                     k, idx_valid, idx, idx_last, exp_idx[k], k == 2);
            n_fails++;
         end
         tick();
      end
      n_checks++;
      if ({idx_valid, done, busy, count, any_resp} !== {1'b0, 1'b1, 1'b1, 8'd3, 1'b1}) begin
         $display("FAIL basic_done: got valid=%0b done=%0b busy=%0b count=%0d any=%0b, want 0 1 1 3 1",
                  idx_valid, done, busy, count, any_resp);
         n_fails++;
      end
      tick();
      n_checks++;
      if ({done, busy, count, any_resp} !== {1'b0, 1'b0, 8'd3, 1'b1}) begin
         $display("FAIL basic_idle: got done=%0b busy=%0b count=%0d any=%0b, want 0 0 3 1",
                  done, busy, count, any_resp);
         n_fails++;
      end
   endtask

   task automatic test_empty();
      tags = '0; start = 1;
      tick();
      start = 0;
      n_checks++;
      if ({idx_valid, done, count, any_resp} !== {1'b0, 1'b1, 8'd0, 1'b0}) begin
         $display("FAIL empty_done: got valid=%0b done=%0b count=%0d any=%0b, want 0 1 0 0",
                  idx_valid, done, count, any_resp);
         n_fails++;
      end
      tick();
      n_checks++;
      if ({done, busy, idx_valid} !== 3'b000) begin
         $display("FAIL empty_pulse: got done=%0b busy=%0b valid=%0b, want 0 0 0", done, busy, idx_valid);
         n_fails++;
      end
   endtask

   task automatic test_backpressure();
      tags = '0; tags[5] = 1; tags[6] = 1;
      idx_ready = 0; start = 1;
      tick();
      start = 0;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if ({idx_valid, idx, idx_last, count} !== {emit_vec(1'b1, 5, 1'b0), 8'd0}) begin
            $display("FAIL stall%0d: got valid=%0b idx=%0d last=%0b count=%0d, want 1 5 0 0",
                     k, idx_valid, idx, idx_last, count);
            n_fails++;
         end
         tick();
      end
      idx_ready = 1;
      tick();
      n_checks++;
      if ({idx_valid, idx, idx_last, count} !== {emit_vec(1'b1, 6, 1'b1), 8'd1}) begin
         $display("FAIL stall_second: got valid=%0b idx=%0d last=%0b count=%0d, want 1 6 1 1",
                  idx_valid, idx, idx_last, count);
         n_fails++;
      end
      tick();
      n_checks++;
      if ({done, count} !== {1'b1, 8'd2}) begin
         $display("FAIL stall_done: got done=%0b count=%0d, want 1 2", done, count);
         n_fails++;
      end
      tick();
   endtask

   task automatic test_ignore_restart();
      tags = '0; tags[0] = 1; tags[50] = 1;
      idx_ready = 1; start = 1;
      tick();
      start = 0;
      n_checks++;
      if ({idx_valid, idx, idx_last} !== emit_vec(1'b1, 0, 1'b0)) begin
         $display("FAIL restart_first: got valid=%0b idx=%0d last=%0b, want 1 0 0", idx_valid, idx, idx_last);
         n_fails++;
      end
      tags = '1; start = 1;
      tick();
      n_checks++;
      if ({idx_valid, idx, idx_last, count} !== {emit_vec(1'b1, 50, 1'b1), 8'd1}) begin
         $display("FAIL restart_second: got valid=%0b idx=%0d last=%0b count=%0d, want 1 50 1 1",
                  idx_valid, idx, idx_last, count);
         n_fails++;
      end
      tick();
      start = 0;
      n_checks++;
      if ({done, count, any_resp} !== {1'b1, 8'd2, 1'b1}) begin
         $display("FAIL restart_done: got done=%0b count=%0d any=%0b, want 1 2 1", done, count, any_resp);
         n_fails++;
      end
      tick();
   endtask

   task automatic test_abort();
      tags = '0; tags[1] = 1; tags[2] = 1; tags[3] = 1;
      idx_ready = 1; start = 1;
      tick();
      start = 0;
      tick();
      n_checks++;
      if ({idx_valid, idx, count} !== {1'b1, 7'd2, 8'd1}) begin
         $display("FAIL abort_pre: got valid=%0b idx=%0d count=%0d, want 1 2 1", idx_valid, idx, count);
         n_fails++;
      end
      idx_ready = 0; abort = 1;
      tick();
      abort = 0;
      n_checks++;
      if ({idx_valid, busy, done, count} !== {1'b0, 1'b0, 1'b0, 8'd1}) begin
         $display("FAIL abort_idle: got valid=%0b busy=%0b done=%0b count=%0d, want 0 0 0 1",
                  idx_valid, busy, done, count);
         n_fails++;
      end
      tick();
      n_checks++;
      if ({done, busy} !== 2'b00) begin
         $display("FAIL abort_nodone: got done=%0b busy=%0b, want 0 0", done, busy);
         n_fails++;
      end
      tags = '0; tags[9] = 1; abort = 1; start = 1;
      tick();
      abort = 0; start = 0;
      n_checks++;
      if ({busy, count} !== {1'b0, 8'd1}) begin
         $display("FAIL abort_beats_start: got busy=%0b count=%0d, want 0 1", busy, count);
         n_fails++;
      end
      tags = '0; tags[7] = 1; idx_ready = 1; start = 1;
      tick();
      start = 0;
      n_checks++;
      if ({idx_valid, idx, idx_last, count} !== {emit_vec(1'b1, 7, 1'b1), 8'd0}) begin
         $display("FAIL abort_restart: got valid=%0b idx=%0d last=%0b count=%0d, want 1 7 1 0",
                  idx_valid, idx, idx_last, count);
         n_fails++;
      end
      tick();
      n_checks++;
      if ({done, count} !== {1'b1, 8'd1}) begin
         $display("FAIL abort_restart_done: got done=%0b count=%0d, want 1 1", done, count);
         n_fails++;
      end
      tick();
   endtask

   task automatic test_reset_mid_emit();
      tags = '0; tags[10] = 1; tags[20] = 1; tags[30] = 1;
      idx_ready = 1; start = 1;
      tick();
      start = 0;
      tick();
      idx_ready = 0;
      n_checks++;
      if ({idx_valid, idx, count} !== {1'b1, 7'd20, 8'd1}) begin
         $display("FAIL rst_pre: got valid=%0b idx=%0d count=%0d, want 1 20 1", idx_valid, idx, count);
         n_fails++;
      end
      #2 RST_N = 1'b0;
      #1;
      n_checks++;
      if ({idx_valid, busy, count, any_resp} !== {1'b0, 1'b0, 8'd0, 1'b0}) begin
         $display("FAIL rst_async: got valid=%0b busy=%0b count=%0d any=%0b, want 0 0 0 0",
                  idx_valid, busy, count, any_resp);
         n_fails++;
      end
      tick();
      RST_N = 1'b1;
      tick();
      tags = '1; idx_ready = 1; start = 1;
      tick();
      start = 0;
      for (int i = 0; i < WORDS; i++) begin
         n_checks++;
         if ({idx_valid, idx, idx_last} !== emit_vec(1'b1, i, i == WORDS - 1)) begin
            $display("FAIL full_emit%0d: got valid=%0b idx=%0d last=%0b, want 1 %0d %0b",
                     i, idx_valid, idx, idx_last, i, i == WORDS - 1);
            n_fails++;
         end
         tick();
      end
      n_checks++;
      if ({done, count, any_resp} !== {1'b1, 8'd100, 1'b1}) begin
         $display("FAIL full_done: got done=%0b count=%0d any=%0b, want 1 100 1", done, count, any_resp);
         n_fails++;
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_empty();
      test_backpressure();
      test_ignore_restart();
      test_abort();
      test_reset_mid_emit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
